guess_entry: RTL and testbench

- Consumes the single-cycle key pulses produced by the key-stroke stabilizer and assembles a player's Mastermind guess of SLOTS colour codes.
- Presents the finished guess to the downstream scoring block through a valid/ready handshake.
- Counts submitted guesses and locks out further entry when the game ends: either a win is reported or MAX_GUESSES is reached.

---
 rtl/guess_entry.sv | 102 ++++++++++
 tb/tb_guess_entry.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// Mastermind guess entry: assembles a guess from key pulses and offers it to the scorer
// over a valid/ready handshake, counting guesses and locking out entry when the game ends.
module guess_entry #(
  parameter int unsigned Slots      = 4,
  parameter int unsigned Colors     = 6,
  parameter int unsigned ColorW     = 3,
  parameter int unsigned CursorW    = 2,
  parameter int unsigned MaxGuesses = 10,
  parameter int unsigned CountW     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     inc_pulse_i,
  input  logic                     next_pulse_i,
  input  logic                     submit_pulse_i,
  input  logic                     game_won_i,
  input  logic                     guess_ready_i,
  output logic [Slots*ColorW-1:0]  guess_o,
  output logic                     guess_valid_o,
  output logic [CursorW-1:0]       cursor_o,
  output logic [CountW-1:0]        guess_count_o,
  output logic                     game_over_o
);

  typedef enum logic [1:0] {StEdit, StOffer, StOver} state_e;

  state_e                    state_q;
  logic [Slots*ColorW-1:0]   guess_q;
  logic                      valid_q;
  logic [CursorW-1:0]        cursor_q;
  logic [CountW-1:0]         count_q;
  logic                      over_q;

  logic [ColorW-1:0]         cur_slot;
  logic [ColorW-1:0]         slot_inc;
  logic [Slots*ColorW-1:0]   guess_inc;
  logic [CursorW-1:0]        cursor_inc;
  logic [CountW-1:0]         count_inc;

  always_comb begin
    cur_slot   = guess_q[cursor_q*ColorW +: ColorW];
    slot_inc   = (cur_slot == ColorW'(Colors - 1)) ? '0 : cur_slot + 1'b1;
    guess_inc  = guess_q;
    guess_inc[cursor_q*ColorW +: ColorW] = slot_inc;
    cursor_inc = (cursor_q == CursorW'(Slots - 1)) ? '0 : cursor_q + 1'b1;
    count_inc  = count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StEdit;
      guess_q  <= '0;
      valid_q  <= 1'b0;
      cursor_q <= '0;
      count_q  <= '0;
      over_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StEdit: begin
          // A win report outranks every key pulse; submit outranks editing.
          if (game_won_i) begin
            state_q <= StOver;
            over_q  <= 1'b1;
          end else if (submit_pulse_i) begin
            state_q <= StOffer;
            valid_q <= 1'b1;
          end else begin
            if (inc_pulse_i)  guess_q  <= guess_inc;
            if (next_pulse_i) cursor_q <= cursor_inc;
          end
        end
        StOffer: begin
          if (guess_ready_i) begin
            valid_q <= 1'b0;
            count_q <= count_inc;
            if (count_inc == CountW'(MaxGuesses)) begin
              state_q <= StOver;
              over_q  <= 1'b1;
            end else begin
              state_q  <= StEdit;
              guess_q  <= '0;
              cursor_q <= '0;
            end
          end
        end
        StOver: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= StEdit;
        end
      endcase
    end
  end

  assign guess_o       = guess_q;
  assign guess_valid_o = valid_q;
  assign cursor_o      = cursor_q;
  assign guess_count_o = count_q;
  assign game_over_o   = over_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed plan plus random traffic, checked against a slot-array
// reference model; submitted guesses are queued and compared when the scorer takes them.
module tb_guess_entry;

  localparam int Slots      = 4;
  localparam int Colors     = 6;
  localparam int MaxGuesses = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inc, nxt, sub, won, rdy;
  logic [11:0] guess;
  logic        guess_valid;
  logic [1:0]  cursor;
  logic [3:0]  guess_count;
  logic        game_over;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model, kept as game-level quantities.
  int          m_slots [Slots];
  int          m_cur;
  int          m_cnt;
  bit          m_offer;
  bit          m_over;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  guess_entry dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .inc_pulse_i    (inc),
    .next_pulse_i   (nxt),
    .submit_pulse_i (sub),
    .game_won_i     (won),
    .guess_ready_i  (rdy),
    .guess_o        (guess),
    .guess_valid_o  (guess_valid),
    .cursor_o       (cursor),
    .guess_count_o  (guess_count),
    .game_over_o    (game_over)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] pack_model();
    logic [11:0] p;
    p = '0;
    for (int i = 0; i < Slots; i++) p[i*3 +: 3] = 3'(m_slots[i]);
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < Slots; i++) m_slots[i] = 0;
    m_cur = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
      m_cnt   = 0;
      m_offer = 0;
      m_over  = 0;
      exp_q.delete();
    end else if (m_over) begin
      // locked
    end else if (m_offer) begin
      if (rdy) begin
        m_offer = 0;
        m_cnt   = m_cnt + 1;
        if (m_cnt == MaxGuesses) m_over = 1;
        else model_clear();
      end
    end else if (won) begin
      m_over = 1;
    end else if (sub) begin
      m_offer = 1;
      exp_q.push_back(pack_model());
    end else begin
      if (inc) m_slots[m_cur] = (m_slots[m_cur] + 1) % Colors;
      if (nxt) m_cur = (m_cur + 1) % Slots;
    end
  end

  // Monitor: whole-state compare every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (rst_n !== 1'b0 && $time > 0) begin
      check("guess",       32'(guess),       32'(pack_model()));
      check("guess_valid", 32'(guess_valid), 32'(m_offer));
      check("cursor",      32'(cursor),      32'(m_cur));
      check("guess_count", 32'(guess_count), 32'(m_cnt));
      check("game_over",   32'(game_over),   32'(m_over));
      if (guess_valid && rdy) begin
        if (exp_q.size() == 0) check("xfer_unexpected", 32'(guess), 32'hffff_ffff);
        else check("xfer_guess", 32'(guess), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit i, input bit n, input bit s, input bit w, input bit r);
    inc = i; nxt = n; sub = s; won = w; rdy = r;
    @(posedge clk);
    #1;
    inc = 0; nxt = 0; sub = 0; won = 0; rdy = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic one_guess(input bit won_in_offer);
    int k;
    for (int j = 0; j < int'($urandom_range(0, 4)); j++)
      step(1'($urandom), 1'($urandom), 0, 0, 0);
    step(0, 0, 1, 0, 1'($urandom));
    k = int'($urandom_range(0, 2));
    for (int j = 0; j < k; j++) step(1'($urandom), 1'($urandom), 1'($urandom), won_in_offer, 0);
    step(0, 0, 0, won_in_offer, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    inc = 0; nxt = 0; sub = 0; won = 0; rdy = 0;
    for (int j = 0; j < 2; j++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    rst_n = 1'b1;
    check("rst_guess", 32'(guess), 0);
    check("rst_valid", 32'(guess_valid), 0);
    check("rst_cursor", 32'(cursor), 0);
    check("rst_count", 32'(guess_count), 0);
    check("rst_over", 32'(game_over), 0);

    for (int j = 0; j < 7; j++) step(1, 0, 0, 0, 0);
    check("colour_wrap", 32'(guess[2:0]), 1);
    for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 0);
    check("cursor_wrap", 32'(cursor), 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("inc_next_cursor", 32'(cursor), 2);
    check("inc_next_slot1", 32'(guess[5:3]), 1);

    do_reset();
    for (int j = 0; j < 3; j++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int j = 0; j < 4; j++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("build_3141", 32'(guess), 32'(12'b001_100_001_011));
    step(0, 0, 1, 0, 0);
    check("submit_latency", 32'(guess_valid), 1);
    for (int j = 0; j < 5; j++) begin
      step(1'($urandom), 1'($urandom), 0, 0, 0);
      check("stall_valid", 32'(guess_valid), 1);
      check("stall_guess", 32'(guess), 32'(12'b001_100_001_011));
    end
    step(0, 0, 0, 0, 1);
    check("xfer_count", 32'(guess_count), 1);
    check("xfer_valid", 32'(guess_valid), 0);
    check("xfer_clear", 32'(guess), 0);
    check("xfer_cursor", 32'(cursor), 0);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    check("prio_guess", 32'(guess), 2);
    check("prio_valid", 32'(guess_valid), 1);
    step(0, 0, 0, 0, 1);

    for (int g = 2; g < MaxGuesses; g++) one_guess(0);
    check("end_count", 32'(guess_count), 10);
    check("end_over", 32'(game_over), 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    check("eleventh_valid", 32'(guess_valid), 0);
    check("eleventh_count", 32'(guess_count), 10);

    do_reset();
    one_guess(0);
    one_guess(1);
    one_guess(0);
    step(1, 1, 1, 1, 0);
    check("win_over", 32'(game_over), 1);
    check("win_count", 32'(guess_count), 3);
    do_reset();
    check("rst2_over", 32'(game_over), 0);
    check("rst2_count", 32'(guess_count), 0);
    step(1, 0, 0, 0, 0);
    check("rst2_entry", 32'(guess), 1);

    for (int j = 0; j < 600; j++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 40) == 0), 1'($urandom));
    end
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
